// File: rtl/sonic_pkg.sv
// Shared sonar definitions: time-of-flight FSM states and the timebase width
// used by the upstream tick counter.
package sonic_pkg;

    localparam int unsigned SONIC_COUNT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        LISTEN
    } tof_state_t;

endpackage

// File: rtl/echo_qualifier.sv
// Run-length qualifier for the echo detect level: counts consecutive high samples
// and flags the start of a run and the sample that completes ECHO_HOLD highs.
module echo_qualifier #(
    parameter int unsigned ECHO_HOLD = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clear,
    input  logic enable,
    input  logic echo,
    output logic run_start,
    output logic qualified
);

    localparam int unsigned RUN_WIDTH = $clog2(ECHO_HOLD + 1);
    localparam logic [RUN_WIDTH-1:0] HOLD_LAST = RUN_WIDTH'(ECHO_HOLD - 1);

    logic [RUN_WIDTH-1:0] run_q;
    logic [RUN_WIDTH-1:0] run_d;
    logic                 sample;

    assign sample = enable && !clear && echo;

    always_comb begin
        run_d = run_q;
        if (clear) begin
            run_d = '0;
        end else if (enable) begin
            run_d = echo ? run_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Both flags describe the current sample so the owner can register its result
    // in the same cycle the run becomes ECHO_HOLD long.
    assign run_start = sample && (run_q == '0);
    assign qualified = sample && (run_q == HOLD_LAST);

endmodule

// File: rtl/echo_tof_capture.sv
// Sonar time-of-flight capture: stamps the ping, blanks ring-down, qualifies the first
// echo run and reports the elapsed ticks or a listen timeout.
module echo_tof_capture
    import sonic_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH   = SONIC_COUNT_WIDTH,
    parameter int unsigned BLANK_TICKS   = 1000,
    parameter int unsigned TIMEOUT_TICKS = 60000,
    parameter int unsigned ECHO_HOLD     = 4
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [COUNT_WIDTH-1:0] count_in,
    input  logic                   start_in,
    input  logic                   echo_in,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] tof_out,
    output logic                   tof_valid_out,
    output logic                   timeout_out
);

    localparam logic [COUNT_WIDTH-1:0] BLANK_LIMIT   = COUNT_WIDTH'(BLANK_TICKS);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_TICKS);

    tof_state_t             state_q;
    logic [COUNT_WIDTH-1:0] start_stamp_q;
    logic [COUNT_WIDTH-1:0] echo_stamp_q;
    logic [COUNT_WIDTH-1:0] elapsed;
    logic [COUNT_WIDTH-1:0] tof_calc;
    logic                   qual_clear;
    logic                   qual_enable;
    logic                   run_start;
    logic                   qualified;

    assign qual_enable = (state_q == LISTEN);
    assign qual_clear  = start_in || (state_q != LISTEN);

    echo_qualifier #(
        .ECHO_HOLD(ECHO_HOLD)
    ) u_echo_qualifier (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear    (qual_clear),
        .enable   (qual_enable),
        .echo     (echo_in),
        .run_start(run_start),
        .qualified(qualified)
    );

    // Modular subtraction keeps timestamps correct across counter wrap.
    assign elapsed = count_in - start_stamp_q;
    // With ECHO_HOLD == 1 the run starts and qualifies on the same sample.
    assign tof_calc = (run_start ? count_in : echo_stamp_q) - start_stamp_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            start_stamp_q <= '0;
            echo_stamp_q  <= '0;
            busy_out      <= 1'b0;
            tof_out       <= '0;
            tof_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            tof_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
            if (start_in) begin
                start_stamp_q <= count_in;
                state_q       <= BLANK;
                busy_out      <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        busy_out <= 1'b0;
                    end
                    BLANK: begin
                        if (elapsed >= BLANK_LIMIT) begin
                            state_q <= LISTEN;
                        end
                    end
                    LISTEN: begin
                        if (run_start) begin
                            echo_stamp_q <= count_in;
                        end
                        if (qualified) begin
                            tof_out       <= tof_calc;
                            tof_valid_out <= 1'b1;
                            state_q       <= IDLE;
                            busy_out      <= 1'b0;
                        end else if (elapsed >= TIMEOUT_LIMIT) begin
                            timeout_out <= 1'b1;
                            state_q     <= IDLE;
                            busy_out    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        busy_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_echo_tof_capture.sv
// Scoreboard bench for echo_tof_capture: stimulus pushes expected pulses, a negedge
// monitor pops and compares each valid/timeout pulse against them.
module tb_echo_tof_capture;

    localparam int unsigned CW = 8;

    logic          clk;
    logic          rst_in;
    logic [CW-1:0] count_in;
    logic          start_in;
    logic          echo_in;
    logic          busy_out;
    logic [CW-1:0] tof_out;
    logic          tof_valid_out;
    logic          timeout_out;

    typedef struct {
        bit          is_timeout;
        logic [CW-1:0] tof;
        logic [CW-1:0] stamp;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    echo_tof_capture #(
        .COUNT_WIDTH  (CW),
        .BLANK_TICKS  (10),
        .TIMEOUT_TICKS(200),
        .ECHO_HOLD    (3)
    ) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .count_in     (count_in),
        .start_in     (start_in),
        .echo_in      (echo_in),
        .busy_out     (busy_out),
        .tof_out      (tof_out),
        .tof_valid_out(tof_valid_out),
        .timeout_out  (timeout_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Advance one clock; the count seen by the DUT at the next edge is count_in+1.
    task automatic cyc(input logic r, input logic s, input logic e);
        @(posedge clk);
        #1;
        count_in = count_in + 8'd1;
        rst_in   = r;
        start_in = s;
        echo_in  = e;
    endtask

    // Idle until the next cyc() call lands on count c.
    task automatic idle_until(input logic [CW-1:0] c);
        logic [CW-1:0] nxt;
        nxt = count_in + 8'd1;
        while (nxt != c) begin
            cyc(1'b0, 1'b0, 1'b0);
            nxt = count_in + 8'd1;
        end
    endtask

    task automatic expect_pulse(input bit is_to, input logic [CW-1:0] tof,
                                input logic [CW-1:0] stamp);
        exp_t e;
        e.is_timeout = is_to;
        e.tof        = tof;
        e.stamp      = stamp;
        sb.push_back(e);
    endtask

    // Monitor: outputs and count_in are both stable at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (tof_valid_out || timeout_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: valid=%0b timeout=%0b tof=%0d at count %0d, expected no pulse",
                         tof_valid_out, timeout_out, tof_out, count_in);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", int'({timeout_out, tof_valid_out}),
                      e.is_timeout ? 2 : 1);
                check("tof_out", int'(tof_out), int'(e.tof));
                check("pulse_count", int'(count_in), int'(e.stamp));
            end
        end
    end

    initial begin
        rst_in   = 1'b1;
        start_in = 1'b0;
        echo_in  = 1'b0;
        count_in = '0;
        repeat (3) cyc(1'b1, 1'b0, 1'b0);
        check("reset_busy", int'(busy_out), 0);
        check("reset_tof", int'(tof_out), 0);
        check("reset_valid", int'(tof_valid_out), 0);
        check("reset_timeout", int'(timeout_out), 0);

        // 1: basic measurement, start 5, echo 40..42 -> tof 35 at count 43
        expect_pulse(1'b0, 8'd35, 8'd43);
        idle_until(8'd5);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd40);
        cyc(1'b0, 1'b0, 1'b1);
        check("busy_listen", int'(busy_out), 1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        check("busy_drop", int'(busy_out), 0);

        // 2: counter wrap, start 250, echo 20..22 -> tof 26
        expect_pulse(1'b0, 8'd26, 8'd23);
        idle_until(8'd250);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd20);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // 3: blanking, echo 3..8 ignored, echo 60..62 -> tof 60
        expect_pulse(1'b0, 8'd60, 8'd63);
        idle_until(8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd3);
        repeat (6) cyc(1'b0, 1'b0, 1'b1);
        check("busy_blank", int'(busy_out), 1);
        idle_until(8'd60);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);

        // 4: glitch then timeout; decision at elapsed 200 (count 44), pulse at 45
        expect_pulse(1'b1, 8'd60, 8'd45);
        idle_until(8'd100);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd120);
        repeat (2) cyc(1'b0, 1'b0, 1'b1);
        idle_until(8'd47);
        cyc(1'b0, 1'b0, 1'b0);
        check("tof_hold_after_timeout", int'(tof_out), 60);
        check("busy_after_timeout", int'(busy_out), 0);

        // 5: restart at 30 aborts first ping silently; echo 70..72 -> tof 40
        expect_pulse(1'b0, 8'd40, 8'd73);
        idle_until(8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd30);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd70);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        idle_until(8'd240);

        // 6: reset during LISTEN with run=2 discards the result
        idle_until(8'd0);
        cyc(1'b0, 1'b1, 1'b0);
        idle_until(8'd20);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        check("rst_mid_busy", int'(busy_out), 0);
        check("rst_mid_tof", int'(tof_out), 0);
        check("rst_mid_valid", int'(tof_valid_out), 0);
        repeat (7) cyc(1'b0, 1'b0, 1'b1);
        idle_until(8'd220);
        cyc(1'b0, 1'b0, 1'b0);
        check("busy_after_reset", int'(busy_out), 0);

        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
